// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch
//  Description : Instruction prefetch unit. Issues sequential fetches to a
//                1-cycle-latency instruction memory and buffers the returned
//                words, tagged with their PCs, in a small show-ahead queue.
//                A redirect flushes the queue, drops any in-flight response
//                and restarts fetching at the redirect target.
//  Ports       : clk            - clock, all state updates on rising edge
//                reset          - asynchronous reset, active low
//                in_mem_addr    - instruction memory address (fetch PC)
//                in_mem_en      - fetch request this cycle
//                in_mem         - memory read data, valid one cycle later
//                redirect_valid - branch/jump redirect strobe
//                redirect_pc    - redirect target address
//                instr_valid    - queue head holds a valid instruction
//                instr_ready    - consumer accepts the head this cycle
//                instr          - instruction at queue head
//                instr_pc       - PC of the instruction at queue head
//                count          - number of valid queue entries
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
   parameter int unsigned         ADDR_W   = 32,
   parameter int unsigned         INSTR_W  = 32,
   parameter int unsigned         DEPTH    = 4,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(4)
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [ADDR_W-1:0]        in_mem_addr,
   output logic                     in_mem_en,
   input  logic [INSTR_W-1:0]       in_mem,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [INSTR_W-1:0]       instr,
   output logic [ADDR_W-1:0]        instr_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned          c_ptr_w     = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]     c_depth_cnt = (c_ptr_w+1)'(DEPTH);
   localparam logic [c_ptr_w+1:0]   c_depth_occ = (c_ptr_w+2)'(DEPTH);
   localparam logic [c_ptr_w:0]     c_one_cnt   = (c_ptr_w+1)'(1);
   localparam logic [c_ptr_w-1:0]   c_one_ptr   = c_ptr_w'(1);

   // Fetch state
   logic [ADDR_W-1:0]   r_fetch_pc;
   logic [ADDR_W-1:0]   r_req_pc;
   logic                r_inflight;

   // Queue state
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_ptr_w:0]    r_count;
   logic [ADDR_W-1:0]   r_mem_pc    [DEPTH];
   logic [INSTR_W-1:0]  r_mem_instr [DEPTH];

   logic                w_pop;
   logic                w_pop_eff;
   logic                w_push;
   logic                w_fetch;
   logic [c_ptr_w+1:0]  w_occ;

   assign w_pop     = (r_count != '0) && instr_ready;
   // A redirect cancels both ends of the queue in the same cycle.
   assign w_pop_eff = w_pop && !redirect_valid;
   assign w_push    = r_inflight && !redirect_valid;

   // Occupancy reserves a slot for the outstanding response so the queue
   // can never be overrun; a simultaneous pop frees one slot for the new
   // request when the queue plus in-flight word are exactly full.
   assign w_occ   = {1'b0, r_count} + (c_ptr_w+2)'(r_inflight);
   assign w_fetch = reset && !redirect_valid &&
                    ((w_occ < c_depth_occ) || ((w_occ == c_depth_occ) && w_pop));

   assign in_mem_addr = r_fetch_pc;
   assign in_mem_en   = w_fetch;
   assign instr_valid = (r_count != '0);
   assign instr       = r_mem_instr[r_rd_ptr];
   assign instr_pc    = r_mem_pc[r_rd_ptr];
   assign count       = r_count;

   // Control state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_inflight <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_fetch) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
            r_req_pc   <= r_fetch_pc;
            r_inflight <= 1'b1;
         end else begin
            r_inflight <= 1'b0;
         end

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_one_ptr;
         end
         if (w_pop_eff) begin
            r_rd_ptr <= r_rd_ptr + c_one_ptr;
         end

         case ({w_push, w_pop_eff})
            2'b10:   r_count <= r_count + c_one_cnt;
            2'b01:   r_count <= r_count - c_one_cnt;
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage: contents are only observed through valid entries,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= r_req_pc;
         r_mem_instr[r_wr_ptr] <= in_mem;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_push && !w_pop_eff && (r_count == c_depth_cnt)))
      else $error("instr_prefetch: push into full queue");
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
module tb_instr_prefetch;

   localparam logic [31:0] c_xor = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_mem_addr;
   logic        in_mem_en;
   logic [31:0] in_mem = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [2:0]  count;

   always #5 clk = ~clk;

   instr_prefetch #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .DEPTH    (4),
      .RESET_PC (32'h0),
      .PC_STEP  (32'h4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_mem_addr    (in_mem_addr),
      .in_mem_en      (in_mem_en),
      .in_mem         (in_mem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .count          (count)
   );

   int          n_pass  = 0;
   int          n_total = 0;

   // Scoreboard: expected PCs in delivery order, and the bench's own fetch PC.
   logic [31:0] sb_q[$];
   logic [31:0] exp_fetch = 32'h0;
   logic [31:0] mon_exp;
   logic        mem_req   = 1'b0;
   logic [31:0] mem_addr  = 32'h0;

   // Instruction memory: one-cycle read latency.
   always @(posedge clk) begin
      if (mem_req) in_mem <= mem_addr ^ c_xor;
   end

   always @(negedge reset) begin
      sb_q.delete();
      exp_fetch = 32'h0;
      mem_req   = 1'b0;
   end

   // Monitor sampled on the falling edge; inputs only change just after rising edges.
   always @(negedge clk) begin
      mem_req  = reset && in_mem_en;
      mem_addr = in_mem_addr;
      if (!reset) begin
         sb_q.delete();
         exp_fetch = 32'h0;
      end else if (redirect_valid) begin
         sb_q.delete();
         exp_fetch = redirect_pc;
      end else begin
         if (instr_valid && instr_ready) begin
            n_total++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", instr_pc, instr);
            end else begin
               mon_exp = sb_q.pop_front();
               if (instr_pc !== mon_exp || instr !== (mon_exp ^ c_xor))
                  $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                           instr_pc, instr, mon_exp, mon_exp ^ c_xor);
               else n_pass++;
            end
         end
         if (in_mem_en) begin
            n_total++;
            if (in_mem_addr !== exp_fetch)
               $display("FAIL sb_fetch_addr: got %h, expected %h", in_mem_addr, exp_fetch);
            else n_pass++;
            sb_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'h4;
         end
      end
   end

   task automatic pulse_reset(input logic rdy);
      @(posedge clk); #1;
      reset       = 1'b0;
      instr_ready = rdy;
      @(posedge clk); #1;
      reset       = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d, expected 0", count); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", instr_valid); else n_pass++;
      n_total++; if (in_mem_en !== 1'b0) $display("FAIL reset_en: got %b, expected 0", in_mem_en); else n_pass++;
      n_total++; if (in_mem_addr !== 32'h0) $display("FAIL reset_addr: got %h, expected 0", in_mem_addr); else n_pass++;
   endtask

   task automatic test_stream();
      logic ev;
      @(posedge clk); #1;
      reset = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (in_mem_en !== 1'b1 || in_mem_addr !== 32'h0)
         $display("FAIL stream_first_req: got en=%b addr=%h, expected en=1 addr=0", in_mem_en, in_mem_addr); else n_pass++;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         ev = (i >= 2);
         n_total++; if (in_mem_addr !== 32'(4*i) || in_mem_en !== 1'b1)
            $display("FAIL stream_addr: got en=%b addr=%h, expected en=1 addr=%h", in_mem_en, in_mem_addr, 32'(4*i)); else n_pass++;
         n_total++; if (instr_valid !== ev)
            $display("FAIL stream_valid: got %b, expected %b at step %0d", instr_valid, ev, i); else n_pass++;
         if (ev) begin
            n_total++; if (instr_pc !== 32'(4*(i-2)))
               $display("FAIL stream_pc: got %h, expected %h", instr_pc, 32'(4*(i-2))); else n_pass++;
         end
      end
   endtask

   task automatic test_stall();
      int          nreq = 0;
      logic [31:0] last = 32'h0;
      pulse_reset(1'b0);
      repeat (10) begin
         @(negedge clk);
         if (in_mem_en) begin nreq++; last = in_mem_addr; end
      end
      n_total++; if (nreq != 4) $display("FAIL stall_nreq: got %0d, expected 4", nreq); else n_pass++;
      n_total++; if (last !== 32'hC) $display("FAIL stall_last_addr: got %h, expected 0000000c", last); else n_pass++;
      n_total++; if (count !== 3'd4) $display("FAIL stall_count: got %0d, expected 4", count); else n_pass++;
      n_total++; if (in_mem_en !== 1'b0) $display("FAIL stall_en: got %b, expected 0", in_mem_en); else n_pass++;
      @(posedge clk); #1 instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (in_mem_en !== 1'b1 || in_mem_addr !== 32'h10)
         $display("FAIL stall_resume: got en=%b addr=%h, expected en=1 addr=00000010", in_mem_en, in_mem_addr); else n_pass++;
      n_total++; if (instr_pc !== 32'h0) $display("FAIL stall_head: got %h, expected 0", instr_pc); else n_pass++;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_redirect();
      pulse_reset(1'b0);
      repeat (4) @(posedge clk);
      #1 redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      n_total++; if (count !== 3'd3) $display("FAIL redir_pre_count: got %0d, expected 3", count); else n_pass++;
      n_total++; if (in_mem_en !== 1'b0) $display("FAIL redir_en: got %b, expected 0", in_mem_en); else n_pass++;
      @(posedge clk); #1 redirect_valid = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (count !== 3'd0 || instr_valid !== 1'b0)
         $display("FAIL redir_flush: got count=%0d valid=%b, expected 0/0", count, instr_valid); else n_pass++;
      n_total++; if (in_mem_en !== 1'b1 || in_mem_addr !== 32'h100)
         $display("FAIL redir_req: got en=%b addr=%h, expected en=1 addr=00000100", in_mem_en, in_mem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_gap: got %b, expected 0", instr_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
         $display("FAIL redir_first: got valid=%b pc=%h, expected 1/00000100", instr_valid, instr_pc); else n_pass++;
      @(negedge clk);
      n_total++; if (instr_pc !== 32'h104) $display("FAIL redir_second: got %h, expected 00000104", instr_pc); else n_pass++;
   endtask

   task automatic test_redirect_pop();
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      n_total++; if (in_mem_en !== 1'b0) $display("FAIL rpop_en: got %b, expected 0", in_mem_en); else n_pass++;
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      n_total++; if (count !== 3'd0 || instr_valid !== 1'b0)
         $display("FAIL rpop_flush: got count=%0d valid=%b, expected 0/0", count, instr_valid); else n_pass++;
      repeat (2) @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200)
         $display("FAIL rpop_first: got valid=%b pc=%h, expected 1/00000200", instr_valid, instr_pc); else n_pass++;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      pulse_reset(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++; if (count !== 3'd2) $display("FAIL rmid_pre_count: got %0d, expected 2", count); else n_pass++;
      #1 reset = 1'b0;
      #1;
      n_total++; if (count !== 3'd0 || instr_valid !== 1'b0)
         $display("FAIL rmid_async: got count=%0d valid=%b, expected 0/0", count, instr_valid); else n_pass++;
      n_total++; if (in_mem_en !== 1'b0 || in_mem_addr !== 32'h0)
         $display("FAIL rmid_fetch: got en=%b addr=%h, expected en=0 addr=0", in_mem_en, in_mem_addr); else n_pass++;
      @(posedge clk); #1 reset = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      n_total++; if (in_mem_en !== 1'b1 || in_mem_addr !== 32'h0)
         $display("FAIL rmid_restart: got en=%b addr=%h, expected en=1 addr=0", in_mem_en, in_mem_addr); else n_pass++;
      repeat (2) @(negedge clk);
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
         $display("FAIL rmid_first: got valid=%b pc=%h, expected 1/0", instr_valid, instr_pc); else n_pass++;
   endtask

   task automatic test_wrap();
      @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      n_total++; if (in_mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h, expected fffffffc", in_mem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (in_mem_addr !== 32'h0) $display("FAIL wrap_zero: got %h, expected 0", in_mem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top: got %h, expected fffffffc", instr_pc); else n_pass++;
      @(negedge clk);
      n_total++; if (instr_pc !== 32'h0) $display("FAIL wrap_pc_zero: got %h, expected 0", instr_pc); else n_pass++;
   endtask

   task automatic test_random_ready();
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1 instr_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_total++; if (count > 3'd4) $display("FAIL rand_count: got %0d, expected <= 4", count); else n_pass++;
      end
      @(posedge clk); #1 instr_ready = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop();
      test_reset_mid();
      test_wrap();
      test_random_ready();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter ADDR_W, default 32, width of fetch addresses and PCs.
REQ-002 Parameter INSTR_W, default 32, width of an instruction word.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 Parameter PC_STEP, default 4, address increment per sequential fetch.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 in_mem_addr  output  ADDR_W  instruction memory address, equal to fetch_pc.
REQ-009 in_mem_en  output  1  fetch request this cycle.
REQ-010 in_mem  input  INSTR_W  instruction memory read data, valid the cycle after a request.
REQ-011 redirect_valid  input  1  branch/jump redirect strobe.
REQ-012 redirect_pc  input  ADDR_W  redirect target address.
REQ-013 instr_valid  output  1  queue head holds a valid instruction.
REQ-014 instr_ready  input  1  consumer accepts the head this cycle.
REQ-015 instr  output  INSTR_W  instruction at queue head.
REQ-016 instr_pc  output  ADDR_W  PC of the instruction at queue head.
REQ-017 count  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-018 Memory model: read latency is exactly 1 cycle; data for the request issued at edge N is sampled at edge N+1.
REQ-019 The block has a pop when instr_valid && instr_ready, and an occupancy equal to count + inflight, where inflight (0/1) marks an outstanding request.
REQ-020 in_mem_en is high when reset is high, redirect_valid is low, and either occupancy < DEPTH or (occupancy == DEPTH and a pop occurs).
REQ-021 At an edge with in_mem_en high, fetch_pc advances by PC_STEP (modulo 2^ADDR_W), req_pc captures the old fetch_pc, and inflight is set; otherwise inflight clears.
REQ-022 At an edge with inflight high and redirect_valid low, {req_pc, in_mem} is pushed at the tail.
REQ-023 The queue is show-ahead: instr and instr_pc reflect the head entry combinationally; instr_valid = (count != 0).
REQ-024 A push and a pop in the same cycle leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-025 The queue never overflows; a push into a full queue is a design error to be flagged by assertion.
REQ-026 A pop when the queue is empty has no effect.
REQ-027 Redirect has priority over everything: at an edge with redirect_valid high, the queue empties (count = 0), the in-flight response is discarded, inflight clears, and fetch_pc loads redirect_pc.
REQ-028 During a redirect cycle, in_mem_en is low and any pop is ignored.
REQ-029 The first request at redirect_pc issues in the cycle after the redirect; its instruction becomes visible 2 edges after the redirect edge.
REQ-030 Sustained throughput is 1 instruction per cycle while instr_ready stays high and no redirect occurs.
REQ-031 instr and instr_pc are don't-care while instr_valid is low.

Reset
REQ-032 While reset is low: fetch_pc = RESET_PC, inflight = 0, pointers = 0, count = 0, instr_valid = 0, in_mem_en = 0.
REQ-033 Asserting reset mid-operation clears all state immediately, including any in-flight response, and that response is never pushed.
REQ-034 Queue data storage needs no reset.
REQ-035 The first request (in_mem_addr = RESET_PC) issues in the first cycle with reset high.

Verification
REQ-036 Scenario: reset release, instr_ready=1, memory returns addr^32'hA5A5_0000 -> in_mem_addr 0,4,8,... one per cycle; instr_valid rises 1 edge after the first request; instr_pc sequence 0,4,8 with no gaps.
REQ-037 Scenario: instr_ready=0 with DEPTH=4 -> exactly 4 requests issue (addr 0..12); count saturates at 4; in_mem_en stays low; raising instr_ready resumes requests at addr 16 with no lost or duplicated PCs.
REQ-038 Scenario: redirect_valid pulse with redirect_pc=0x100 while count=3 and a request is in flight -> count=0 and instr_valid=0 next cycle; the stale response is dropped; the next instr_pc values are 0x100, 0x104.
REQ-039 Scenario: redirect_valid and a pop in the same cycle -> the redirect wins; no old instruction is delivered afterward.
REQ-040 Scenario: reset driven low while count=2 and inflight=1 -> all outputs reach reset values asynchronously; after release, fetch restarts at RESET_PC.
REQ-041 Scenario: fetch_pc = 2^ADDR_W - 4 -> the next in_mem_addr wraps to 0; pointer wrap after DEPTH+1 pushes and pops keeps FIFO order intact.
